// File: rtl/artifact_blanker_pkg.sv
// Shared definitions for the artifact blanker: FSM encoding, sample width
// and the saturating counter helper used for the hold-event count.
package artifact_pkg;

   localparam int SAMPLE_W = 16;
   localparam int STATE_W  = 2;

   typedef logic signed [SAMPLE_W-1:0] sample_t;
   typedef logic [STATE_W-1:0]         state_t;

   localparam state_t ST_PASS  = 2'd0;
   localparam state_t ST_HOLD  = 2'd1;
   localparam state_t ST_RAMP  = 2'd2;
   localparam state_t ST_FAULT = 2'd3;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      if (v == 16'hFFFF) begin
         return v;
      end else begin
         return v + 16'd1;
      end
   endfunction

endpackage

// File: rtl/artifact_blanker_crossfade_mac.sv
// Combinational crossfade: held + ((live - held) * step_n) >>> RAMP_LOG2.
// The product is kept wide enough that no intermediate overflows, and the
// final value always lies between held and live, so truncating back to the
// sample width is exact. At step_n = 2^RAMP_LOG2 the result equals live.
module crossfade_mac
   import artifact_pkg::*;
#(
   parameter int RAMP_LOG2 = 2
) (
   input  logic signed [SAMPLE_W-1:0] i_held,
   input  logic signed [SAMPLE_W-1:0] i_live,
   input  logic        [RAMP_LOG2:0]  i_step_n,
   output logic signed [SAMPLE_W-1:0] o_blend
);

   localparam int DW = SAMPLE_W + 1;
   localparam int PW = 18 + RAMP_LOG2;

   logic signed [DW-1:0] w_diff;
   logic signed [PW-1:0] w_diff_ext;
   logic signed [PW-1:0] w_step_ext;
   logic signed [PW-1:0] w_held_ext;
   logic signed [PW-1:0] w_prod;
   logic signed [PW-1:0] w_shift;

   // 17-bit difference cannot overflow for any pair of 16-bit samples.
   assign w_diff     = {i_live[SAMPLE_W-1], i_live} - {i_held[SAMPLE_W-1], i_held};
   assign w_diff_ext = {{(PW-DW){w_diff[DW-1]}}, w_diff};
   // Step count is a non-negative magnitude, so it is zero-extended.
   assign w_step_ext = {{(PW-RAMP_LOG2-1){1'b0}}, i_step_n};
   assign w_held_ext = {{(PW-SAMPLE_W){i_held[SAMPLE_W-1]}}, i_held};
   assign w_prod     = w_diff_ext * w_step_ext;
   // Arithmetic shift floors toward minus infinity for negative deltas.
   assign w_shift    = w_prod >>> RAMP_LOG2;
   assign o_blend    = SAMPLE_W'(w_held_ext + w_shift);

endmodule

// File: rtl/artifact_blanker.sv
// Artifact blanker: passes ECG samples through, holds the last good output
// while the range guard asserts freeze, crossfades back to live over
// 2^RAMP_LOG2 samples on release, and latches a fault on an over-long freeze.
module artifact_blanker
   import artifact_pkg::*;
#(
   parameter int RAMP_LOG2  = 2,
   parameter int MAX_FREEZE = 20000
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_freeze,
   input  logic signed [SAMPLE_W-1:0] i_in_sample,
   input  logic                       i_in_valid,
   input  logic                       i_clear_fault,
   output logic signed [SAMPLE_W-1:0] o_out_sample,
   output logic                       o_out_valid,
   output logic                       o_blanking,
   output logic                       o_fault,
   output logic        [15:0]         o_event_count
);

   localparam int SW  = RAMP_LOG2 + 1;
   localparam int FCW = $clog2(MAX_FREEZE + 1);
   localparam logic [SW-1:0]  STEP_LAST = SW'(1 << RAMP_LOG2);
   // Entering HOLD already counts one frozen clock, so the escalation fires
   // on the clock that brings the count up to MAX_FREEZE.
   localparam logic [FCW-1:0] FRZ_LAST  = FCW'(MAX_FREEZE - 1);

   state_t                      r_state;
   logic signed [SAMPLE_W-1:0]  r_out_sample;
   logic                        r_out_valid;
   logic                        r_blanking;
   logic                        r_fault;
   logic [15:0]                 r_event_count;
   logic signed [SAMPLE_W-1:0]  r_held;
   logic [SW-1:0]               r_step;
   logic [FCW-1:0]              r_frz_cnt;

   state_t                      w_state_nx;
   logic signed [SAMPLE_W-1:0]  w_out_nx;
   logic signed [SAMPLE_W-1:0]  w_held_nx;
   logic [SW-1:0]               w_step_nx;
   logic [FCW-1:0]              w_frz_nx;
   logic [15:0]                 w_evt_nx;
   logic [SW-1:0]               w_step_n;
   logic signed [SAMPLE_W-1:0]  w_blend;

   assign w_step_n = r_step + SW'(1);

   crossfade_mac #(
      .RAMP_LOG2 (RAMP_LOG2)
   ) u_mac (
      .i_held   (r_held),
      .i_live   (i_in_sample),
      .i_step_n (w_step_n),
      .o_blend  (w_blend)
   );

   // Next-state and next-output decode for the blanking FSM.
   always_comb begin
      w_state_nx = r_state;
      w_out_nx   = r_out_sample;
      w_held_nx  = r_held;
      w_step_nx  = r_step;
      w_frz_nx   = r_frz_cnt;
      w_evt_nx   = r_event_count;
      case (r_state)
         ST_PASS: begin
            if (i_freeze) begin
               // Freeze wins over a same-cycle strobe: output stays put.
               w_state_nx = ST_HOLD;
               w_held_nx  = r_out_sample;
               w_evt_nx   = sat_inc16(r_event_count);
               w_frz_nx   = FCW'(1);
            end else if (i_in_valid) begin
               w_out_nx = i_in_sample;
            end else begin
               w_out_nx = r_out_sample;
            end
         end
         ST_HOLD: begin
            if (i_in_valid) begin
               w_out_nx = r_held;
            end else begin
               w_out_nx = r_out_sample;
            end
            if (i_freeze) begin
               w_frz_nx = r_frz_cnt + FCW'(1);
               if (r_frz_cnt >= FRZ_LAST) begin
                  w_state_nx = ST_FAULT;
               end else begin
                  w_state_nx = ST_HOLD;
               end
            end else begin
               w_state_nx = ST_RAMP;
               w_step_nx  = {SW{1'b0}};
               w_frz_nx   = {FCW{1'b0}};
            end
         end
         ST_RAMP: begin
            if (i_freeze) begin
               // Re-freeze mid-ramp holds the partially blended value.
               w_state_nx = ST_HOLD;
               w_held_nx  = r_out_sample;
               w_evt_nx   = sat_inc16(r_event_count);
               w_frz_nx   = FCW'(1);
            end else if (i_in_valid) begin
               w_out_nx = w_blend;
               if (w_step_n == STEP_LAST) begin
                  w_state_nx = ST_PASS;
                  w_step_nx  = {SW{1'b0}};
               end else begin
                  w_state_nx = ST_RAMP;
                  w_step_nx  = w_step_n;
               end
            end else begin
               w_out_nx = r_out_sample;
            end
         end
         ST_FAULT: begin
            if (i_in_valid) begin
               w_out_nx = {SAMPLE_W{1'b0}};
            end else begin
               w_out_nx = r_out_sample;
            end
            if (i_clear_fault && !i_freeze) begin
               w_state_nx = ST_PASS;
               w_frz_nx   = {FCW{1'b0}};
            end else begin
               w_state_nx = ST_FAULT;
            end
         end
         default: begin
            w_state_nx = ST_PASS;
         end
      endcase
   end

   // State, datapath and status registers; flags track the next state so
   // they change on the same clock as the state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= ST_PASS;
         r_out_sample  <= {SAMPLE_W{1'b0}};
         r_out_valid   <= 1'b0;
         r_blanking    <= 1'b0;
         r_fault       <= 1'b0;
         r_event_count <= 16'd0;
         r_held        <= {SAMPLE_W{1'b0}};
         r_step        <= {SW{1'b0}};
         r_frz_cnt     <= {FCW{1'b0}};
      end else begin
         r_state       <= w_state_nx;
         r_out_sample  <= w_out_nx;
         r_out_valid   <= i_in_valid;
         r_blanking    <= (w_state_nx != ST_PASS);
         r_fault       <= (w_state_nx == ST_FAULT);
         r_event_count <= w_evt_nx;
         r_held        <= w_held_nx;
         r_step        <= w_step_nx;
         r_frz_cnt     <= w_frz_nx;
      end
   end

   assign o_out_sample  = r_out_sample;
   assign o_out_valid   = r_out_valid;
   assign o_blanking    = r_blanking;
   assign o_fault       = r_fault;
   assign o_event_count = r_event_count;

endmodule

// File: tb/tb_artifact_blanker.sv
// Scoreboard bench for artifact_blanker: each strobed input pushes its
// hand-computed output; a negedge monitor pops and compares on out_valid.
module tb_artifact_blanker;

   logic               clk;
   logic               rst;
   logic               i_freeze;
   logic signed [15:0] i_in_sample;
   logic               i_in_valid;
   logic               i_clear_fault;
   logic signed [15:0] o_out_sample;
   logic               o_out_valid;
   logic               o_blanking;
   logic               o_fault;
   logic [15:0]        o_event_count;

   logic signed [15:0] exp_q[$];
   int                 n_chk;
   int                 n_err;

   artifact_blanker #(
      .RAMP_LOG2  (2),
      .MAX_FREEZE (100)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .i_freeze      (i_freeze),
      .i_in_sample   (i_in_sample),
      .i_in_valid    (i_in_valid),
      .i_clear_fault (i_clear_fault),
      .o_out_sample  (o_out_sample),
      .o_out_valid   (o_out_valid),
      .o_blanking    (o_blanking),
      .o_fault       (o_fault),
      .o_event_count (o_event_count)
   );

   // 100 MHz clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Safety net so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string name, input int act, input int exp);
      n_chk = n_chk + 1;
      if (act != exp) begin
         n_err = n_err + 1;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // One input cycle; a strobe registers its expected output.
   task automatic step(input logic v, input logic signed [15:0] s,
                       input logic f, input logic c, input logic signed [15:0] e);
      @(posedge clk);
      #1;
      i_in_valid    = v;
      i_in_sample   = s;
      i_freeze      = f;
      i_clear_fault = c;
      if (v) exp_q.push_back(e);
   endtask

   // Output monitor: compare every presented sample with the scoreboard.
   always @(negedge clk) begin
      if (o_out_valid === 1'b1) begin
         n_chk = n_chk + 1;
         if (exp_q.size() == 0) begin
            n_err = n_err + 1;
            $display("FAIL out_sample: got %0d with no expected value queued", o_out_sample);
         end else begin
            logic signed [15:0] e;
            e = exp_q.pop_front();
            if (o_out_sample !== e) begin
               n_err = n_err + 1;
               $display("FAIL out_sample: got %0d expected %0d", o_out_sample, e);
            end
         end
      end
   end

   initial begin
      n_chk = 0;
      n_err = 0;
      rst = 1'b1;
      i_freeze = 1'b0;
      i_in_sample = 16'sd0;
      i_in_valid = 1'b0;
      i_clear_fault = 1'b0;

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_sample", int'(o_out_sample), 0);
      chk("rst_out_valid", int'(o_out_valid), 0);
      chk("rst_blanking", int'(o_blanking), 0);
      chk("rst_fault", int'(o_fault), 0);
      chk("rst_event_count", int'(o_event_count), 0);
      rst = 1'b0;

      // Passthrough.
      step(1'b1, 16'sd100, 1'b0, 1'b0, 16'sd100);
      step(1'b1, -16'sd200, 1'b0, 1'b0, -16'sd200);
      step(1'b1, 16'sd300, 1'b0, 1'b0, 16'sd300);
      step(1'b0, 16'sd0, 1'b0, 1'b0, 16'sd0);
      chk("pass_blanking", int'(o_blanking), 0);
      chk("pass_event_count", int'(o_event_count), 0);

      // Hold 50 clocks at 1000 while live is 5000, then ramp to 2000.
      step(1'b1, 16'sd1000, 1'b0, 1'b0, 16'sd1000);
      for (int i = 0; i < 50; i++) begin
         step(1'b1, 16'sd5000, 1'b1, 1'b0, 16'sd1000);
         if (i == 1) chk("hold_blanking", int'(o_blanking), 1);
      end
      step(1'b1, 16'sd2000, 1'b0, 1'b0, 16'sd1000);
      step(1'b1, 16'sd2000, 1'b0, 1'b0, 16'sd1250);
      step(1'b1, 16'sd2000, 1'b0, 1'b0, 16'sd1500);
      step(1'b1, 16'sd2000, 1'b0, 1'b0, 16'sd1750);
      step(1'b1, 16'sd2000, 1'b0, 1'b0, 16'sd2000);
      step(1'b0, 16'sd0, 1'b0, 1'b0, 16'sd0);
      chk("ramp_done_blanking", int'(o_blanking), 0);
      chk("ramp_event_count", int'(o_event_count), 1);

      // Re-freeze after the 1500 ramp output; new ramp from 1500 to 3500.
      step(1'b1, 16'sd1000, 1'b0, 1'b0, 16'sd1000);
      step(1'b1, 16'sd5000, 1'b1, 1'b0, 16'sd1000);
      step(1'b1, 16'sd5000, 1'b1, 1'b0, 16'sd1000);
      step(1'b1, 16'sd2000, 1'b0, 1'b0, 16'sd1000);
      step(1'b1, 16'sd2000, 1'b0, 1'b0, 16'sd1250);
      step(1'b1, 16'sd2000, 1'b0, 1'b0, 16'sd1500);
      step(1'b1, 16'sd2000, 1'b1, 1'b0, 16'sd1500);
      for (int i = 0; i < 3; i++) step(1'b1, 16'sd9999, 1'b1, 1'b0, 16'sd1500);
      chk("refreeze_event_count", int'(o_event_count), 3);
      chk("refreeze_blanking", int'(o_blanking), 1);
      step(1'b1, 16'sd3500, 1'b0, 1'b0, 16'sd1500);
      step(1'b1, 16'sd3500, 1'b0, 1'b0, 16'sd2000);
      step(1'b1, 16'sd3500, 1'b0, 1'b0, 16'sd2500);
      step(1'b1, 16'sd3500, 1'b0, 1'b0, 16'sd3000);
      step(1'b1, 16'sd3500, 1'b0, 1'b0, 16'sd3500);

      // Negative-going ramp: -1000 to 1000.
      step(1'b1, -16'sd1000, 1'b0, 1'b0, -16'sd1000);
      for (int i = 0; i < 3; i++) step(1'b1, 16'sd777, 1'b1, 1'b0, -16'sd1000);
      step(1'b1, 16'sd1000, 1'b0, 1'b0, -16'sd1000);
      step(1'b1, 16'sd1000, 1'b0, 1'b0, -16'sd500);
      step(1'b1, 16'sd1000, 1'b0, 1'b0, 16'sd0);
      step(1'b1, 16'sd1000, 1'b0, 1'b0, 16'sd500);
      step(1'b1, 16'sd1000, 1'b0, 1'b0, 16'sd1000);

      // Floor rounding: 0 to -3 gives -1, -2, -3, -3.
      step(1'b1, 16'sd0, 1'b0, 1'b0, 16'sd0);
      for (int i = 0; i < 2; i++) step(1'b1, 16'sd55, 1'b1, 1'b0, 16'sd0);
      step(1'b1, -16'sd3, 1'b0, 1'b0, 16'sd0);
      step(1'b1, -16'sd3, 1'b0, 1'b0, -16'sd1);
      step(1'b1, -16'sd3, 1'b0, 1'b0, -16'sd2);
      step(1'b1, -16'sd3, 1'b0, 1'b0, -16'sd3);
      step(1'b1, -16'sd3, 1'b0, 1'b0, -16'sd3);

      // Timeout: the 100th consecutive frozen clock escalates to FAULT.
      step(1'b1, 16'sd42, 1'b0, 1'b0, 16'sd42);
      for (int k = 1; k <= 100; k++) begin
         step(1'b1, 16'sd7, 1'b1, 1'b0, 16'sd42);
         if (k == 100) chk("fault_before_limit", int'(o_fault), 0);
      end
      step(1'b1, 16'sd7, 1'b1, 1'b0, 16'sd0);
      chk("fault_at_limit", int'(o_fault), 1);
      chk("fault_blanking", int'(o_blanking), 1);
      chk("fault_event_count", int'(o_event_count), 6);
      step(1'b1, 16'sd8, 1'b1, 1'b1, 16'sd0);
      step(1'b1, 16'sd8, 1'b1, 1'b0, 16'sd0);
      chk("clear_while_frozen", int'(o_fault), 1);
      step(1'b1, 16'sd9, 1'b0, 1'b1, 16'sd0);
      step(1'b1, 16'sd11, 1'b0, 1'b0, 16'sd11);
      chk("clear_fault", int'(o_fault), 0);
      chk("clear_blanking", int'(o_blanking), 0);

      // Reset during RAMP.
      step(1'b1, 16'sd500, 1'b0, 1'b0, 16'sd500);
      step(1'b1, 16'sd0, 1'b1, 1'b0, 16'sd500);
      step(1'b1, 16'sd0, 1'b0, 1'b0, 16'sd500);
      step(1'b1, 16'sd1500, 1'b0, 1'b0, 16'sd750);
      @(posedge clk);
      #1;
      rst = 1'b1;
      i_in_valid = 1'b0;
      i_freeze = 1'b0;
      @(posedge clk);
      #1;
      chk("rst2_out_sample", int'(o_out_sample), 0);
      chk("rst2_out_valid", int'(o_out_valid), 0);
      chk("rst2_blanking", int'(o_blanking), 0);
      chk("rst2_event_count", int'(o_event_count), 0);
      rst = 1'b0;
      step(1'b1, 16'sd1234, 1'b0, 1'b0, 16'sd1234);
      step(1'b0, 16'sd0, 1'b0, 1'b0, 16'sd0);
      step(1'b0, 16'sd0, 1'b0, 1'b0, 16'sd0);
      chk("post_rst_blanking", int'(o_blanking), 0);
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/artifact_blanker.md
Name: artifact_blanker

Overview:
- Downstream responder to the front-end range guard's freeze flag.
- Passes ECG samples through in normal operation.
- While freeze is asserted, substitutes the last good output (blanking).
- On release, crossfades from the held value back to the live signal over 2^RAMP_LOG2 samples, avoiding step discontinuities that would trigger the QRS detector.
- Latches a fault when a freeze outlasts MAX_FREEZE clocks.

Parameters:
- RAMP_LOG2, 2, log2 of the number of valid samples in the release crossfade (1..8).
- MAX_FREEZE, 20000, number of consecutive frozen clocks that escalates to FAULT.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- freeze  in  1  from the range guard; level-sensitive
- in_sample  in  16 signed  live sample
- in_valid  in  1  qualifies in_sample, single-cycle strobe
- clear_fault  in  1  single-cycle pulse; exits FAULT
- out_sample  out  16 signed  registered output sample
- out_valid  out  1  registered; equals in_valid delayed 1 clk
- blanking  out  1  high when state != PASS
- fault  out  1  high in FAULT
- event_count  out  16  count of HOLD entries, saturates at 0xFFFF

Behaviour:
- Reset: state=PASS; out_sample=0, out_valid=0, blanking=0, fault=0, event_count=0; held=0, step=0, frz_cnt=0.
- Reset mid-operation aborts any hold, ramp or fault immediately.
- Latency: out_valid and out_sample update 1 clk after an in_valid cycle. out_sample holds its value between strobes.
- State is updated every clk. Freeze is sampled every clk, independent of in_valid.
- PASS:
  - on in_valid, out_sample <= in_sample.
  - If freeze=1: go to HOLD, held <= out_sample (pre-update value), event_count++ (saturating), frz_cnt <= 1.
  - If freeze=1 and in_valid occur in the same cycle, the output is held, not in_sample.
- HOLD:
  - on in_valid, out_sample <= held.
  - While freeze=1: frz_cnt++ each clk. When frz_cnt reaches MAX_FREEZE, go to FAULT.
  - If freeze=0: go to RAMP, step <= 0, frz_cnt <= 0.
- RAMP:
  - On in_valid: step_n = step+1; out_sample <= held + ((in_sample - held) * step_n) >>> RAMP_LOG2.
  - Arithmetic: 17-bit signed difference, (18+RAMP_LOG2)-bit signed product, arithmetic right shift (floor toward -inf). Result is exactly in_sample when step_n = 2^RAMP_LOG2; no saturation needed.
  - When step_n = 2^RAMP_LOG2: go to PASS.
  - If freeze=1 in RAMP: held <= out_sample (current ramped value), event_count++, frz_cnt <= 1, go to HOLD. Takes priority over in_valid that cycle, so the output is held.
- FAULT:
  - fault=1, blanking=1; on in_valid, out_sample <= 0.
  - Leave FAULT only when clear_fault=1 and freeze=0 in the same clk. Then go to PASS, frz_cnt <= 0.
  - clear_fault is ignored in all other states.
- blanking and fault are registered outputs and change in the same clk as the state register.
- event_count does not wrap.

Decomposition:
- Shared package artifact_pkg:
  - State encoding: ST_PASS, ST_HOLD, ST_RAMP, ST_FAULT (2 bits).
  - SAMPLE_W=16.
  - Saturating-increment helper function.
- Natural sub-module: crossfade_mac. Combinational held/live/step -> blended 16-bit value; parameterised by RAMP_LOG2.
- FSM, counters and output registers stay in the top-level module.

Test Plan:
1. Passthrough: freeze=0, in_valid each clk with 100, -200, 300 -> out_sample 100, -200, 300 one clk later; blanking=0, event_count=0.
2. Hold and ramp: RAMP_LOG2=2, last output 1000; freeze high 50 clks with live=5000 -> output 1000 throughout. After release, live=2000 -> 1250, 1500, 1750, 2000, then PASS and blanking=0; event_count=1.
3. Negative ramp: held=-1000, live=1000 -> -500, 0, 500, 1000. Floor check: held=0, live=-3 -> -1, -2, -3, -3.
4. Re-freeze mid-ramp: freeze reasserts after output 1500 -> held=1500 and output 1500 while frozen, event_count=2, new ramp starts from 1500.
5. Timeout: MAX_FREEZE=100, freeze held 100 clks -> fault=1 at clk 100, outputs 0. clear_fault while freeze=1 is ignored. clear_fault with freeze=0 -> PASS, fault=0.
6. Reset during RAMP: all outputs return to reset values next clk; the next in_valid passes through unmodified.
